// File: rtl/napalm_pkg.sv
// Shared architectural defaults and register-file types used by the
// decode, hazard and writeback stages.
package napalm_pkg;

    localparam int ARCH_DATA_W = 32;
    localparam int ARCH_ADDR_W = 5;

    typedef logic [ARCH_ADDR_W-1:0] reg_addr_t;
    typedef logic [ARCH_DATA_W-1:0] reg_data_t;

    // r0 is hardwired to zero
    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port of reg_file_mp: zero-register check, optional same-cycle
// write bypass (REG_FILE_BYPASS_EN) and busy-bit select.
module reg_file_rd_port
    import napalm_pkg::*;
#(
    parameter int DATA_W = ARCH_DATA_W,
    parameter int ADDR_W = ARCH_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]             ra,
    input  logic [DEPTH-1:0][DATA_W-1:0]  gpr,
    input  logic [DEPTH-1:0]              busy,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             wa,
    input  logic [DATA_W-1:0]             wd,
    output logic [DATA_W-1:0]             rd,
    output logic                          rbusy
);

    logic ra_zero;
    assign ra_zero = (ra == ADDR_W'(ZERO_REG));

`ifdef REG_FILE_BYPASS_EN
    logic byp_hit;
    assign byp_hit = we && (wa == ra) && !ra_zero;
`else
    // Write-side inputs only matter when forwarding is compiled in.
    logic unused_wr;
    assign unused_wr = ^{we, wa, wd};
`endif

    // Resolve read data and busy status for this port
    always_comb begin
        rd    = gpr[ra];
        rbusy = busy[ra];
`ifdef REG_FILE_BYPASS_EN
        if (byp_hit) rd = wd;
`endif
        if (ra_zero) begin
            rd    = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port GPR file with pending-write scoreboard.
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle write forwarding).
module reg_file_mp
    import napalm_pkg::*;
#(
    parameter int DATA_W = ARCH_DATA_W,
    parameter int ADDR_W = ARCH_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    input  logic                       mark_en,
    input  logic [ADDR_W-1:0]          mark_a,
    input  logic                       flush
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] gpr_q, gpr_d;
    logic [DEPTH-1:0]             busy_q, busy_d;

    logic wr_hit, mark_hit;
    assign wr_hit   = we      && (wa     != ADDR_W'(ZERO_REG));
    assign mark_hit = mark_en && (mark_a != ADDR_W'(ZERO_REG));

    // Next-state: data write, then busy update with flush > mark > write-clear
    always_comb begin
        gpr_d  = gpr_q;
        busy_d = busy_q;
        if (wr_hit) begin
            gpr_d[wa]  = wd;
            busy_d[wa] = 1'b0;
        end
        if (mark_hit) busy_d[mark_a] = 1'b1;
        if (flush)    busy_d = '0;
    end

    // Storage and scoreboard registers, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr_q  <= '0;
            busy_q <= '0;
        end else begin
            gpr_q  <= gpr_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_file_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_port (
            .ra    (ra[i*ADDR_W +: ADDR_W]),
            .gpr   (gpr_q),
            .busy  (busy_q),
            .we    (we),
            .wa    (wa),
            .wd    (wd),
            .rd    (rd[i*DATA_W +: DATA_W]),
            .rbusy (rbusy[i])
        );
    end

endmodule
